// File: rtl/range_arb_pkg.sv
// range_arb_pkg: shared FSM state type, default sizes and index-width helper for the lane arbiters
package range_arb_pkg;
  typedef enum logic {IDLE, LOCK} state_t;
  localparam int W_DEF = 4;
  localparam int N_DEF = 4;
  localparam int MAXB_DEF = 4;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or above ptr, wrapping
//   req   in  N   request vector
//   ptr   in  IW  highest-priority index (must be < N)
//   idx   out IW  chosen index (0 when none)
//   found out 1   any request set
module rr_pick
  import range_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [2*N-1:0] rot;
  logic [IW:0] sum;
  // rot[k] is the request at (ptr+k) wrapped, so the lowest set bit is the winner
  assign rot = {req, req} >> ptr;
  always_comb begin
    idx = '0;
    found = 1'b0;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IW + 1)'(k);
        idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/range_lane_arbiter.sv
// range_lane_arbiter: round-robin burst arbiter sharing one registered W-bit lane among N requesters
//   clk/rst                      clock, asynchronous active-low reset
//   req_valid/req_data/req_last  per-requester beats (requester i at req_data[i*W +: W])
//   req_ready                    one-hot accept to the granted requester
//   out_valid/data/id/last       registered output beat, source index, end-of-grant flag
//   out_ready                    downstream accept
//   busy                         high while a grant is held
module range_lane_arbiter
  import range_arb_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF,
  parameter int IW = clog2_min1(N),
  parameter int MAXB = MAXB_DEF,
  parameter int CW = $clog2(MAXB + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_id,
  output logic           out_last,
  input  logic           out_ready,
  output logic           busy
);
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, grant_id, pick_id, nxt_ptr;
  logic [CW-1:0] beat_cnt, cnt_inc;
  logic [W-1:0] g_data;
  logic pick_found, lock, accept, g_last, end_beat;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .idx  (pick_id),
    .found(pick_found)
  );

  assign lock = state == LOCK;
  assign busy = lock;
  // the output register may load while it drains, so accept whenever it empties this edge
  assign req_ready = (lock && (!out_valid || out_ready)) ? N'(1) << grant_id : '0;
  // req_ready is one-hot on grant_id, so masking selects the granted requester's signals
  assign accept = |(req_valid & req_ready);
  assign g_last = |(req_last & req_ready);
  assign g_data = W'(req_data >> (32'(grant_id) * W));
  assign cnt_inc = beat_cnt + CW'(1);
  assign end_beat = g_last || cnt_inc == CW'(MAXB);
  assign nxt_ptr = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);

  always_comb begin
    state_nxt = lock ? ((accept && end_beat) ? IDLE : LOCK) : (pick_found ? LOCK : IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
      out_last <= 1'b0;
    end else begin
      if (!lock && pick_found) begin
        grant_id <= pick_id;
        beat_cnt <= '0;
      end
      if (accept) begin
        beat_cnt <= cnt_inc;
        out_data <= g_data;
        out_id <= grant_id;
        out_last <= end_beat;
      end
      if (accept && end_beat) rr_ptr <= nxt_ptr;
      out_valid <= accept || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_range_lane_arbiter.sv
// tb_range_lane_arbiter: scoreboard bench with per-requester source queues and directed plus random traffic
module tb_range_lane_arbiter;
  localparam int W = 4;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic out_valid, out_last, out_ready, busy;
  logic [W-1:0] out_data;
  logic [IW-1:0] out_id;

  range_lane_arbiter #(.W(W), .N(N), .MAXB(MAXB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_cmp = 0;
  int n_fail = 0;
  beat_t src_q[N][$];
  beat_t exp_q[N][$];
  int obs_id[$];
  int obs_cyc[$];
  int run[N];
  int ready_mode = 0;
  bit rnd_stall = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // expected out_last depends only on this requester's own beat history: its last flag or the MAXB-th beat of a grant
  task automatic issue(input int i, input logic [W-1:0] d, input logic l);
    logic lo;
    lo = l || (run[i] + 1 == MAXB);
    run[i] = lo ? 0 : run[i] + 1;
    src_q[i].push_back('{d: d, l: l});
    exp_q[i].push_back('{d: d, l: lo});
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int lim);
    int t;
    t = 0;
    while (pending() && t < lim) begin
      @(posedge clk);
      t++;
    end
    check("drain_done", 32'(t < lim), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(nm, 32'(out_valid), 1);
  endtask

  task automatic chk_seq(input string nm, input int base, input int ids[$]);
    check({nm, "_count"}, obs_id.size() - base, ids.size());
    foreach (ids[k]) if (base + k < obs_id.size()) check(nm, obs_id[base + k], ids[k]);
  endtask

  task automatic chk_gap(input string nm, input int idx, input int gap);
    if (idx < obs_cyc.size()) check(nm, obs_cyc[idx] - obs_cyc[idx - 1], gap);
    else check({nm, "_missing"}, obs_cyc.size(), idx + 1);
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_out_valid"}, 32'(out_valid), 0);
    check({nm, "_out_data"}, 32'(out_data), 0);
    check({nm, "_out_id"}, 32'(out_id), 0);
    check({nm, "_out_last"}, 32'(out_last), 0);
    check({nm, "_req_ready"}, 32'(req_ready), 0);
    check({nm, "_busy"}, 32'(busy), 0);
  endtask

  // source driver: presents each requester's queue head, pops it on the handshake just before the edge
  initial begin
    logic [N-1:0] fire;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) for (int i = 0; i < N; i++) src_q[i].delete();
      for (int i = 0; i < N; i++) begin
        req_valid[i] = src_q[i].size() > 0 && !(rnd_stall && $urandom_range(3) == 0);
        req_data[i*W +: W] = src_q[i].size() > 0 ? src_q[i][0].d : W'($urandom);
        req_last[i] = src_q[i].size() > 0 ? src_q[i][0].l : 1'($urandom);
      end
      out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(1)) : 1'b0;
      #4;
      fire = req_valid & req_ready;
      for (int i = 0; i < N; i++) if (fire[i]) void'(src_q[i].pop_front());
    end
  end

  // monitor: compares every transferred beat against the scoreboard and checks hold stability
  initial begin
    bit hold, in_grant;
    logic [W-1:0] hd;
    logic [IW-1:0] hid, gid;
    logic hl;
    beat_t e;
    hold = 0;
    in_grant = 0;
    hd = '0;
    hid = '0;
    gid = '0;
    hl = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        for (int i = 0; i < N; i++) exp_q[i].delete();
        hold = 0;
        in_grant = 0;
      end else begin
        check("ready_onehot0", 32'($onehot0(req_ready)), 1);
        if (hold) begin
          check("hold_valid", 32'(out_valid), 1);
          check("hold_data", 32'(out_data), 32'(hd));
          check("hold_id", 32'(out_id), 32'(hid));
          check("hold_last", 32'(out_last), 32'(hl));
        end
        hold = out_valid && !out_ready;
        hd = out_data;
        hid = out_id;
        hl = out_last;
        if (out_valid && out_ready) begin
          obs_id.push_back(int'(out_id));
          obs_cyc.push_back(cyc);
          if (exp_q[out_id].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: id %0d data %0h with nothing outstanding", out_id, out_data);
          end else begin
            e = exp_q[out_id].pop_front();
            check("out_data", 32'(out_data), 32'(e.d));
            check("out_last", 32'(out_last), 32'(e.l));
          end
          if (in_grant) check("grant_id_stable", 32'(out_id), 32'(gid));
          in_grant = !out_last;
          gid = out_id;
        end
      end
    end
  end

  initial begin
    int base, t0, t, len;
    int seq[$];
    for (int i = 0; i < N; i++) run[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // fairness: two 1-beat bursts per requester
    base = obs_id.size();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) issue(i, W'(i * 3 + r + 1), 1'b1);
    drain(500);
    seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_seq("rr_order", base, seq);
    for (int k = 1; k < 8; k++) chk_gap("rr_bubble_gap", base + k, 2);

    // single requester, latency and last placement
    base = obs_id.size();
    t0 = cyc;
    issue(2, 4'd3, 1'b0);
    issue(2, 4'd5, 1'b0);
    issue(2, 4'd7, 1'b1);
    drain(500);
    seq = '{2, 2, 2};
    chk_seq("single_id", base, seq);
    for (int k = 0; k < 3; k++)
      if (base + k < obs_cyc.size()) check("single_latency", obs_cyc[base + k], t0 + 2 + k);

    // rr_ptr now 3: requester 3 beats requester 0
    base = obs_id.size();
    issue(0, 4'd9, 1'b1);
    issue(3, 4'd10, 1'b1);
    drain(500);
    seq = '{3, 0};
    chk_seq("ptr_after_grant", base, seq);

    // MAXB cap: requester 1 streams 8 beats without last; requester 2 gets in between
    base = obs_id.size();
    for (int k = 0; k < 8; k++) issue(1, W'(k + 1), 1'b0);
    issue(2, 4'd15, 1'b1);
    drain(500);
    seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
    chk_seq("maxb_order", base, seq);
    chk_gap("maxb_bubble", base + 4, 2);

    // backpressure: hold output for 3 cycles, then stream at one beat per cycle
    ready_mode = 2;
    base = obs_id.size();
    for (int k = 0; k < 4; k++) issue(2, W'(k + 1), k == 3);
    wait_valid("bp_first_valid");
    for (int k = 0; k < 3; k++) begin
      check("bp_req_ready_low", 32'(req_ready), 0);
      check("bp_data_held", 32'(out_data), 1);
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
    drain(500);
    for (int k = 1; k < 4; k++) chk_gap("bp_stream_gap", base + k, 1);

    // stall mid-burst: requester 0 runs dry while requester 3 waits
    base = obs_id.size();
    issue(0, 4'd11, 1'b0);
    t = 0;
    while (obs_id.size() == base && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall_first_beat", 32'(obs_id.size() > base), 1);
    issue(3, 4'd12, 1'b0);
    issue(3, 4'd13, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall_busy", 32'(busy), 1);
      check("stall_no_ready3", 32'(req_ready[3]), 0);
    end
    issue(0, 4'd14, 1'b0);
    issue(0, 4'd6, 1'b1);
    drain(500);
    seq = '{0, 0, 0, 3, 3};
    chk_seq("stall_order", base, seq);

    // asynchronous reset during LOCK with a held output beat
    ready_mode = 2;
    for (int k = 0; k < 4; k++) issue(1, W'(k + 9), k == 3);
    wait_valid("rst_pre_valid");
    check("rst_pre_busy", 32'(busy), 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int i = 0; i < N; i++) run[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    base = obs_id.size();
    for (int i = N - 1; i >= 0; i--) issue(i, W'(i + 2), 1'b1);
    drain(500);
    seq = '{0, 1, 2, 3};
    chk_seq("post_rst_order", base, seq);

    // randomized bursts with random stalls and backpressure
    rnd_stall = 1;
    ready_mode = 1;
    for (int it = 0; it < 60; it++) begin
      @(posedge clk);
      #1;
      t = $urandom_range(N - 1);
      len = $urandom_range(6, 1);
      for (int k = 0; k < len; k++) issue(t, W'($urandom), k == len - 1);
      if ($urandom_range(1) == 1) repeat ($urandom_range(4)) @(posedge clk);
    end
    drain(20000);
    rnd_stall = 0;
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
